// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if
//   Bundles the pixel-request side and the VGA-adapter side of plot_arbiter.
//   The master drives the requests. The slave (the arbiter) returns the
//   acks and the registered pixel.
//
//   Handshake: requester i offers a pixel by holding req[i] together with its
//   x/y/colour lanes. The pixel counts as transferred in the cycle where
//   req[i] and ack[i] are both high. A requester keeps its fields stable
//   until that cycle. last[i] with req[i] marks the final pixel of a burst.
//
//   req        : 4-bit per-requester request (0=erase, 1=ground, 2=dino, 3=tree)
//   last       : 4-bit per-requester final-pixel flag
//   req_x      : 4 x 8-bit packed x coordinates
//   req_y      : 4 x 7-bit packed y coordinates
//   req_colour : 4 x 3-bit packed colours
//   ack        : one-hot accept, combinational
//   x/y/colour : registered pixel to the VGA adapter
//   plot       : registered write strobe
//   busy       : a grant is held
//   grant_id   : current or most recent grantee
interface plot_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_colour;
    logic [3:0]  ack;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic [1:0]  grant_id;

    modport master (
        output req, last, req_x, req_y, req_colour,
        input  ack, x, y, colour, plot, busy, grant_id
    );

    modport slave (
        input  req, last, req_x, req_y, req_colour,
        output ack, x, y, colour, plot, busy, grant_id
    );
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Round-robin arbiter that serialises pixel bursts from four drawing
//   engines onto one VGA adapter write port. A grant is held for a whole
//   burst, which ends when the grantee presents a pixel with last high.
//   During the burst, the grantee may stall by dropping req.
//   The accepted pixel appears on x/y/colour with plot one cycle later.
//
//   Optional feature: when PLOT_ARBITER_CLIP_EN is defined, the arbiter
//   acknowledges pixels outside the 160x120 screen (x>159 or y>119) but
//   never plots them.
//
//   Ports:
//     clock      : system clock, rising edge
//     reset      : synchronous, active-high reset
//     bus        : plot_arbiter_if.slave (requests in, acks and pixel out)
//     dbg_state  : FSM state (0=IDLE, 1=BURST)
//     dbg_rr_ptr : round-robin search start pointer
module plot_arbiter (
    input  logic                 clock,
    input  logic                 reset,
    plot_arbiter_if.slave        bus,
    output logic                 dbg_state,
    output logic [1:0]           dbg_rr_ptr
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;

    logic [3:0] ack_c;
    logic [1:0] cand;
    logic       found;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       clip;

    // Fields of the current grantee's lane.
    always_comb begin
        pix_x      = 8'd0;
        pix_y      = 7'd0;
        pix_colour = 3'd0;
        case (grant_id_q)
            2'd0: begin pix_x = bus.req_x[7:0];   pix_y = bus.req_y[6:0];   pix_colour = bus.req_colour[2:0];  end
            2'd1: begin pix_x = bus.req_x[15:8];  pix_y = bus.req_y[13:7];  pix_colour = bus.req_colour[5:3];  end
            2'd2: begin pix_x = bus.req_x[23:16]; pix_y = bus.req_y[20:14]; pix_colour = bus.req_colour[8:6];  end
            default: begin pix_x = bus.req_x[31:24]; pix_y = bus.req_y[27:21]; pix_colour = bus.req_colour[11:9]; end
        endcase
    end

`ifdef PLOT_ARBITER_CLIP_EN
    assign clip = (pix_x > 8'd159) || (pix_y > 7'd119);
`else
    assign clip = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        ack_c      = 4'b0000;
        cand       = 2'd0;
        found      = 1'b0;

        case (state_q)
            IDLE: begin
                // The first requester at or after rr_ptr wins. The 2-bit add wraps mod 4.
                for (int k = 0; k < 4; k++) begin
                    cand = rr_ptr_q + 2'(k);
                    if (!found && bus.req[cand]) begin
                        found      = 1'b1;
                        grant_id_d = cand;
                        state_d    = BURST;
                    end
                end
            end
            default: begin
                // Only the grantee is heard. Other requesters wait, and so does last.
                ack_c[grant_id_q] = bus.req[grant_id_q];
                if (bus.req[grant_id_q] && bus.last[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_id_q + 2'd1;
                end
            end
        endcase

        // A clipped pixel is consumed, but the outputs keep the last plotted pixel.
        if ((ack_c != 4'b0000) && !clip) begin
            x_d      = pix_x;
            y_d      = pix_y;
            colour_d = pix_colour;
            plot_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            grant_id_q <= 2'd0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'd0;
            plot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
        end
    end

    assign bus.ack      = ack_c;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.busy     = (state_q == BURST);
    assign bus.grant_id = grant_id_q;
    assign dbg_state    = state_q;
    assign dbg_rr_ptr   = rr_ptr_q;

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;

  logic       clock;
  logic       reset;
  logic       dbg_state;
  logic [1:0] dbg_rr_ptr;

  plot_arbiter_if bus();

  plot_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];   // {x, y, colour} of pixels expected to be plotted

  // ---------------- reference model ----------------
  // The bench tracks the arbiter as "who holds the screen" and "where the
  // round-robin search starts". It also records the last pixel written.
  bit       m_busy;
  int       m_gid;
  int       m_rr;
  bit       m_plot;
  int       m_x, m_y, m_c;
  logic [3:0] obs_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit off_screen(input int px, input int py);
`ifdef PLOT_ARBITER_CLIP_EN
    return (px > 159) || (py > 119);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_rr = 0; m_plot = 0;
    m_x = 0; m_y = 0; m_c = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, check ack, advance the model, then check
  // the registered outputs after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [31:0] rx, input logic [27:0] ry,
                      input logic [11:0] rc, input logic rst);
    logic [3:0] e_ack;
    logic [17:0] pix;
    int px, py, pc;
    bus.req = r; bus.last = l; bus.req_x = rx; bus.req_y = ry; bus.req_colour = rc;
    reset = rst;
    #1;
    e_ack = 4'b0000;
    if (m_busy && r[m_gid]) e_ack[m_gid] = 1'b1;
    obs_ack = bus.ack;
    check_eq("ack", bus.ack, e_ack);
    check_eq("ack_onehot", ($countones(bus.ack) <= 1), 1);

    if (rst) begin
      model_reset();
    end else begin
      m_plot = 0;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && r[(m_rr + k) % 4]) begin
            m_busy = 1;
            m_gid  = (m_rr + k) % 4;
          end
        end
      end else if (r[m_gid]) begin
        px = int'(rx >> (8 * m_gid)) & 8'hFF;
        py = int'(ry >> (7 * m_gid)) & 7'h7F;
        pc = int'(rc >> (3 * m_gid)) & 3'h7;
        if (!off_screen(px, py)) begin
          m_plot = 1; m_x = px; m_y = py; m_c = pc;
          exp_q.push_back({8'(px), 7'(py), 3'(pc)});
        end
        if (l[m_gid]) begin
          m_busy = 0;
          m_rr   = (m_gid + 1) % 4;
        end
      end
    end

    @(posedge clock);
    #1;
    check_eq("plot", bus.plot, m_plot);
    check_eq("busy", bus.busy, m_busy);
    check_eq("state", dbg_state, m_busy);
    check_eq("grant_id", bus.grant_id, m_gid);
    check_eq("rr_ptr", dbg_rr_ptr, m_rr);
    check_eq("x", bus.x, m_x);
    check_eq("y", bus.y, m_y);
    check_eq("colour", bus.colour, m_c);
    if (bus.plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 1, 0);
      end else begin
        pix = exp_q.pop_front();
        check_eq("sb_pixel", {bus.x, bus.y, bus.colour}, pix);
      end
    end
  endtask

  task automatic idle_step(input logic [3:0] r, input logic [3:0] l);
    step(r, l, {4{8'd20}}, {4{7'd30}}, {4{3'd5}}, 1'b0);
  endtask

  task automatic do_reset();
    step(4'b0000, 4'b0000, '0, '0, '0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int order[5] = '{0, 1, 2, 3, 0};
  bit exp_clip_plot;

  initial begin
    bus.req = '0; bus.last = '0; bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();
    check_eq("rst_plot", bus.plot, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_xyc", {bus.x, bus.y, bus.colour}, 0);

    // Single request from requester 2
    step(4'b0100, 4'b0100, {4{8'd10}}, {4{7'd110}}, {4{3'b001}}, 1'b0);
    check_eq("single_busy", bus.busy, 1);
    check_eq("single_gid", bus.grant_id, 2);
    step(4'b0100, 4'b0100, {4{8'd10}}, {4{7'd110}}, {4{3'b001}}, 1'b0);
    check_eq("single_ack", obs_ack, 4'b0100);
    check_eq("single_plot", bus.plot, 1);
    check_eq("single_x", bus.x, 10);
    check_eq("single_y", bus.y, 110);
    check_eq("single_c", bus.colour, 3'b001);
    check_eq("single_done", bus.busy, 0);
    idle_step(4'b0000, 4'b0000);
    check_eq("idle_noplot", bus.plot, 0);
    check_eq("idle_hold_x", bus.x, 10);

    // Contention: all four request, two pixels per burst
    do_reset();
    for (int b = 0; b < 5; b++) begin
      idle_step(4'b1111, 4'b0000);
      check_eq("rr_order", bus.grant_id, order[b]);
      idle_step(4'b1111, 4'b0000);
      idle_step(4'b1111, 4'b1111);
    end

    // Stall: grantee 1 drops req while requester 3 waits
    do_reset();
    idle_step(4'b0010, 4'b0000);
    idle_step(4'b1010, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      idle_step(4'b1000, 4'b1000);
      check_eq("stall_gid", bus.grant_id, 1);
      check_eq("stall_ack3", obs_ack[3], 0);
      check_eq("stall_plot", bus.plot, 0);
    end
    idle_step(4'b1010, 4'b0010);
    check_eq("stall_end_ack", obs_ack, 4'b0010);
    idle_step(4'b1000, 4'b0000);
    check_eq("stall_next_gid", bus.grant_id, 3);
    idle_step(4'b1000, 4'b1000);

    // Reset mid-burst at pixel 5 of 16 from requester 0
    do_reset();
    idle_step(4'b0001, 4'b0000);
    for (int p = 0; p < 4; p++) idle_step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0000, {4{8'd20}}, {4{7'd30}}, {4{3'd5}}, 1'b1);
    check_eq("rstmid_plot", bus.plot, 0);
    check_eq("rstmid_busy", bus.busy, 0);
    check_eq("rstmid_rr", dbg_rr_ptr, 0);
    idle_step(4'b0110, 4'b0000);
    check_eq("rstmid_gid", bus.grant_id, 1);
    idle_step(4'b0110, 4'b0010);

    // Wrap: grantee 3 completes with 1001 pending
    do_reset();
    idle_step(4'b1000, 4'b0000);
    idle_step(4'b1001, 4'b1000);
    check_eq("wrap_rr", dbg_rr_ptr, 0);
    idle_step(4'b1001, 4'b0000);
    check_eq("wrap_gid", bus.grant_id, 0);
    idle_step(4'b1001, 4'b0001);

    // Clip candidate: x=200, y=50
    do_reset();
    step(4'b0001, 4'b0001, {4{8'd200}}, {4{7'd50}}, {4{3'd3}}, 1'b0);
    step(4'b0001, 4'b0001, {4{8'd200}}, {4{7'd50}}, {4{3'd3}}, 1'b0);
`ifdef PLOT_ARBITER_CLIP_EN
    exp_clip_plot = 1'b0;
`else
    exp_clip_plot = 1'b1;
`endif
    check_eq("clip_ack", obs_ack, 4'b0001);
    check_eq("clip_plot", bus.plot, exp_clip_plot);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), 4'($urandom) & 4'($urandom), $urandom, 28'($urandom), 12'($urandom),
           ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req  input  4  per-requester pixel-burst request; index 0=erase, 1=ground, 2=dino, 3=tree.
REQ-004 last  input  4  per-requester flag; high with req marks the final pixel of the burst.
REQ-005 req_x  input  32  four packed 8-bit x coordinates; requester i uses bits [8i+7:8i].
REQ-006 req_y  input  28  four packed 7-bit y coordinates; requester i uses bits [7i+6:7i].
REQ-007 req_colour  input  12  four packed 3-bit colours; requester i uses bits [3i+2:3i].
REQ-008 ack  output  4  combinational one-hot; ack[i] high means requester i's current pixel is accepted this cycle.
REQ-009 x  output  8  registered pixel x to the VGA adapter.
REQ-010 y  output  7  registered pixel y to the VGA adapter.
REQ-011 colour  output  3  registered pixel colour to the VGA adapter.
REQ-012 plot  output  1  registered write strobe to the VGA adapter.
REQ-013 busy  output  1  high while a grant is held (state BURST).
REQ-014 grant_id  output  2  index of the current or most recent grantee.

Function
REQ-015 FSM SHALL have exactly two states: IDLE and BURST.
REQ-016 IDLE, any req high: next edge enters BURST, grant_id = first requester with req high, searched round-robin from rr_ptr upward (mod 4).
REQ-017 IDLE, req==0: SHALL stay IDLE; ack SHALL be 0.
REQ-018 BURST: ack[grant_id] = req[grant_id]; all other ack bits SHALL be 0.
REQ-019 Any cycle with ack[g]=1: x/y/colour SHALL load requester g's fields and plot SHALL be 1 on the following cycle; otherwise plot SHALL be 0 (one-cycle latency, one pixel per cycle maximum).
REQ-020 BURST, req[g]=1 and last[g]=1: pixel accepted; next state IDLE; rr_ptr = (g+1) mod 4.
REQ-021 BURST, req[g]=0: SHALL hold grant (stall), no ack, plot=0 next cycle; other requests SHALL NOT preempt.
REQ-022 last[i] SHALL be ignored unless req[i] and grant_id==i.
REQ-023 Requests arriving while BURST SHALL wait; no request is lost or reordered beyond round-robin order.
REQ-024 IDLE to BURST SHALL cost exactly one cycle with no ack; single-pixel burst (req and last high at grant) therefore completes in 2 cycles and a new grant is possible on the next cycle after returning to IDLE.
REQ-025 Round-robin wrap: pointer after grantee 3 SHALL be 0.
REQ-026 x/y/colour SHALL hold last plotted value when plot=0.

Reset
REQ-027 reset high at an edge SHALL force: state IDLE, rr_ptr=0, grant_id=0, plot=0, x=0, y=0, colour=0, busy=0.
REQ-028 reset mid-burst SHALL abandon the burst without a further plot; ack SHALL be 0 in the cycle after the reset edge until a new grant.

Configuration
REQ-029 Macro PLOT_ARBITER_CLIP_EN: when defined, an accepted pixel with x>159 or y>119 SHALL be acked normally but plot SHALL stay 0 for it; when undefined, every accepted pixel SHALL produce plot=1 regardless of coordinates.

Verification
REQ-030 Single request: req[2]=1, last[2]=1, x=10, y=110, colour=001 from IDLE -> cycle 1 busy=1, grant_id=2; cycle 2 ack[2]=1; cycle 3 plot=1, x=10, y=110, colour=001, busy=0.
REQ-031 Contention: req=1111 held, each burst 2 pixels -> grant order 0,1,2,3,0; never two ack bits high.
REQ-032 Stall: grantee 1 drops req for 3 cycles mid-burst while req[3]=1 -> grant_id stays 1, plot=0 for those 3 cycles, ack[3]=0 until req[1]&last[1] accepted.
REQ-033 Reset mid-burst: reset at pixel 5 of 16 from requester 0 -> next cycle plot=0, busy=0, rr_ptr=0; next grant with req=0110 goes to 1.
REQ-034 Clip: x=200, y=50 accepted -> with PLOT_ARBITER_CLIP_EN ack=1, plot=0; without, plot=1, x=200.
REQ-035 Wrap: grant 3 completes with req=1001 pending -> next grant_id=0.
